// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, reads a 1-cycle synchronous imem and buffers words in a prefetch FIFO.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            fetch_misaligned
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            kill;
  logic            halted;
  logic [XLEN-1:0] target;

  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;

  logic            push;
  logic            pop;
  logic [AW+1:0]   credit_used;

  assign if_valid  = (count != '0);
  assign pop       = if_valid & if_ready;
  assign push      = inflight & !kill & !redirect_valid;
  assign imem_addr = fetch_pc;

  // A request is only issued if its response is guaranteed a FIFO slot.
  assign credit_used = {1'b0, count} + (AW+2)'(inflight) - (AW+2)'(pop);
  assign imem_req    = !reset & !halted & !redirect_valid & (credit_used < DEPTH_W);

  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
  assign if_instr = if_valid ? instr_mem[rd_ptr] : '0;

`ifdef IFU_MISALIGN_TRAP_EN
  assign target           = redirect_pc;
  assign fetch_misaligned = halted;

  // Misaligned redirect parks fetch until reset or an aligned redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= |redirect_pc[1:0];
    end
  end
`else
  assign target           = redirect_pc & ~XLEN'(3);
  assign fetch_misaligned = 1'b0;
  assign halted           = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      kill     <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= target;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      // A redirect flushes the buffer and overrides any pop in the same cycle.
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
